// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the binary-to-BCD converter
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DASH_NIBBLE = 4'hF;

    // Largest value that fits in the given number of decimal digits.
    function automatic longint unsigned max_val(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 to any nibble >= 5
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter, one bit per clock
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = max_val(DIGITS);
    localparam logic [BCD_W-1:0] DASH_WORD = {DIGITS{DASH_NIBBLE}};

    state_t           state;
    logic [SR_W-1:0]  sreg;
    logic [CNT_W-1:0] count;
    logic             ovf_pend;
    logic [BCD_W-1:0] adj_bcd;
    logic [SR_W:0]    next_sreg;
    logic             ovf_final;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sreg[BIN_W + i*DIGIT_W +: DIGIT_W]),
            .dout (adj_bcd[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Bit SR_W is what falls off the top of the BCD field; only out-of-range
    // inputs can produce it, so folding it into the overflow flag is a no-op
    // for valid values and keeps the flag self-consistent.
    assign next_sreg = {adj_bcd, sreg[BIN_W-1:0], 1'b0};
    assign ovf_final = ovf_pend | next_sreg[SR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            count    <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg     <= {{BCD_W{1'b0}}, bin_in};
                        ovf_pend <= (64'(bin_in) > MAX_VAL);
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg     <= next_sreg[SR_W-1:0];
                    count    <= count + CNT_W'(1);
                    ovf_pend <= ovf_final;
                    if (count == CNT_W'(BIN_W - 1)) begin
                        bcd_out  <= ovf_final ? DASH_WORD : next_sreg[SR_W-1:BIN_W];
                        overflow <= ovf_final;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int n_pass;
    int n_total;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Launches one conversion from idle and waits (bounded) for its done pulse.
    // lat counts clock edges from the accepting edge to the done cycle.
    task automatic run_conv(input logic [13:0] v, output int lat, output int busy_cnt);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        if (!done) $display("FAIL timeout: no done for bin_in=%0d", v);
    endtask

    int lat, bcnt, ndone, last_done, gap_bad, wide_bad, val_bad;
    logic prev_done;

    initial begin
        vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{14'd0,     16'h0000, 1'b0};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{14'd10000, 16'hFFFF, 1'b1};
        vecs[4]  = '{14'd16383, 16'hFFFF, 1'b1};
        vecs[5]  = '{14'd42,    16'h0042, 1'b0};
        vecs[6]  = '{14'd1,     16'h0001, 1'b0};
        vecs[7]  = '{14'd10,    16'h0010, 1'b0};
        vecs[8]  = '{14'd8191,  16'h8191, 1'b0};
        vecs[9]  = '{14'd5000,  16'h5000, 1'b0};
        vecs[10] = '{14'd9998,  16'h9998, 1'b0};
        vecs[11] = '{14'd10001, 16'hFFFF, 1'b1};

        n_pass  = 0;
        n_total = 0;
        start   = 1'b0;
        bin_in  = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bin, lat, bcnt);
            check($sformatf("vec%0d_bcd", i), 32'(bcd_out), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd14);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd14);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_bcd_held", i), 32'(bcd_out), 32'(vecs[i].bcd));
        end

        // start pulses and bin_in changes while busy must not disturb the result
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd5;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd777;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'd3210;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("busy_ignore_bcd", 32'(bcd_out), 32'h0005);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("busy_ignore_no_extra_done", 32'(ndone), 32'd0);

        // start held high: one result every 15 cycles, each done one cycle wide
        @(negedge clk);
        bin_in    = 14'd5;
        start     = 1'b1;
        ndone     = 0;
        last_done = -1;
        gap_bad   = 0;
        wide_bad  = 0;
        val_bad   = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) wide_bad++;
                if (last_done >= 0 && c - last_done != 15) gap_bad++;
                if (bcd_out !== 16'h0005) val_bad++;
                last_done = c;
                ndone++;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("held_start_done_count", 32'(ndone), 32'd5);
        check("held_start_gap_errors", 32'(gap_bad), 32'd0);
        check("held_start_wide_done", 32'(wide_bad), 32'd0);
        check("held_start_value_errors", 32'(val_bad), 32'd0);
        repeat (20) @(negedge clk);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd8765;
        @(negedge clk);
        start  = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_bcd", 32'(bcd_out), 32'd0);
        check("midreset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset_no_done", 32'(ndone), 32'd0);
        run_conv(14'd321, lat, bcnt);
        check("after_reset_bcd", 32'(bcd_out), 32'h0321);
        check("after_reset_latency", 32'(lat), 32'd14);

        // sampled sweep of the whole input range against a decimal model
        for (int v = 0; v < 16384; v += 41) begin
            run_conv(14'(v), lat, bcnt);
            check($sformatf("sweep_%0d_bcd", v), 32'(bcd_out), 32'(model_bcd(v)));
            check($sformatf("sweep_%0d_ovf", v), 32'(overflow), (v > 9999) ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock. It sits directly upstream of the 4-digit multiplexed seven-segment driver and produces its 16-bit packed BCD word (digit 0 in bits [3:0]). Values outside the displayable range produce all-0xF nibbles, which the driver renders as dashes.

Parameters:
BIN_W, 14, width of binary input (default covers 0..16383).
DIGITS, 4, number of BCD digits produced; max displayable value is 10^DIGITS-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only when idle
bin_in  input  BIN_W  unsigned binary value; sampled on accepted start only
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: bcd_out/overflow just updated
bcd_out  output  4*DIGITS  packed BCD result, held until next completion
overflow  output  1  last result exceeded 10^DIGITS-1; held with bcd_out

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, shift/count registers=0.
- States: IDLE, SHIFT.
- IDLE with start=1 at edge k:
  - Load shift reg {bcd=0, bin=bin_in}.
  - Latch ovf_pend = (bin_in > 10^DIGITS-1).
  - Set count=0 and busy=1; go to SHIFT.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3 (4-bit, no carry out of nibble).
  - Then the whole register shifts left 1, MSB of bin entering bit 0 of the BCD field; count++.
- After BIN_W shift edges (edge k+BIN_W):
  - bcd_out <= ovf_pend ? all nibbles 4'hF : final BCD field.
  - overflow <= ovf_pend; done <= 1; busy <= 0; state <= IDLE.
- Latency: done high in the cycle following edge k+BIN_W, exactly BIN_W cycles after the start edge. busy is high for exactly BIN_W cycles.
- done is registered and clears on the next edge unless another completion occurs (it cannot occur back-to-back).
- start while busy=1: ignored, no queueing. bin_in changes during SHIFT: ignored.
- start asserted in the done cycle: accepted, since state is IDLE. Back-to-back throughput is one result per BIN_W+1 cycles.
- BCD field width is 4*DIGITS. Upper-bit truncation for out-of-range inputs is harmless because the result is replaced by 0xF nibbles.
- Reset mid-conversion: immediate abort to reset values, no done pulse. Previous bcd_out is lost (reset to 0).
- bin_in = 0 yields bcd_out = 0 with the normal latency (no short-circuit).
- bcd_out never changes except at a completion edge or reset, so the downstream driver sees glitch-free data.

Decomposition:
- Shared package bcd_pkg:
  - state enum (IDLE, SHIFT)
  - DIGIT_W=4
  - DASH_NIBBLE=4'hF
  - function max_val(DIGITS)=10^DIGITS-1
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 then +3" correction, instantiated DIGITS times via generate.

Test Plan:
1. Reset, start with bin_in=1234 -> busy=1 for 14 cycles; done pulse exactly 14 cycles after start edge; bcd_out=16'h1234, overflow=0.
2. bin_in=0, then bin_in=9999 -> 16'h0000, then 16'h9999; both with overflow=0 and identical latency.
3. bin_in=10000 and bin_in=16383 -> bcd_out=16'hFFFF, overflow=1; a following 42 gives 16'h0042, overflow=0.
4. start=1 held continuously with bin_in=5 -> conversions every 15 cycles, each done one cycle wide; start pulses and bin_in changes during busy do not alter the result.
5. rst_n low at cycle 7 of a conversion of 8765 -> outputs at reset values asynchronously, no done; new start with 321 -> 16'h0321.
6. Exhaustive sweep 0..16383 with scoreboard -> bcd_out matches decimal digits (or 16'hFFFF for >9999) on every done.
